// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family.
//   fifo_depth          : word count from address width
//   read_mode_e         : standard registered read or first-word-fall-through
//   fifo_thresholds_ok  : legality of the almost-full / almost-empty thresholds
package fifo_pkg;

    typedef enum logic {
        READ_STD  = 1'b0,
        READ_FWFT = 1'b1
    } read_mode_e;

    function automatic int unsigned fifo_depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    // Almost-full must lie in 1..DEPTH, almost-empty in 0..DEPTH-1.
    function automatic bit fifo_thresholds_ok(input int unsigned asize,
                                              input int unsigned afull_th,
                                              input int unsigned aempty_th);
        int unsigned depth;
        depth = fifo_depth(asize);
        return (afull_th >= 32'd1) && (afull_th <= depth) && (aempty_th <= depth - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DSIZE x 2**ASIZE, with registered read (1-cycle latency).
//   clk           : clock
//   rst_n         : synchronous active-low reset of the read-data register only
//   wen/waddr/wdata : write port
//   ren/raddr     : read port; rdata updates at the edge where ren is high, holds otherwise
//   rdata         : registered read data
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             ren,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    // Storage array: no reset, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// selectable FWFT read mode and sticky overflow/underflow flags.
//   wclk, wrst_n        : clock, synchronous active-low reset
//   winc, wdata         : push request and data
//   wfull, walmost_full : full, count >= AFULL_TH
//   rinc, rdata         : pop request and read data
//   rempty, ralmost_empty : no word poppable, count <= AEMPTY_TH
//   count               : words held, including the FWFT output register
//   overflow, underflow : sticky error flags, cleared by clr_err
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ASIZE     = 8,
    parameter int unsigned AFULL_TH  = fifo_depth(ASIZE) - 4,
    parameter int unsigned AEMPTY_TH = 4,
    parameter int unsigned FWFT      = 0
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned DEPTH = fifo_depth(ASIZE);
    localparam int unsigned CW    = ASIZE + 1;
    localparam read_mode_e  MODE  = (FWFT != 0) ? READ_FWFT : READ_STD;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    // Elaboration-time parameter legality.
    if (!fifo_thresholds_ok(ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
        $error("sync_fifo_ctrl: AFULL_TH/AEMPTY_TH out of legal range");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("sync_fifo_ctrl: FWFT must be 0 or 1");
    end

    logic [ASIZE-1:0] wptr, rptr;
    logic [CW-1:0]    count_q, count_nxt, mem_words;
    logic             wfull_q, walmost_full_q, rempty_q, ralmost_empty_q;
    logic             overflow_q, underflow_q;
    logic             mid_valid_q, mid_valid_nxt;
    logic [DSIZE-1:0] out_q, ram_rdata;
    logic             push, pop, out_valid, out_load, ram_ren, rempty_nxt;
    logic             ovf_set, udf_set;

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (wclk),
        .rst_n (wrst_n),
        .wen   (push && wrst_n),
        .waddr (wptr),
        .wdata (wdata),
        .ren   (ram_ren),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // Acceptance, next count and the FWFT prefetch pipeline
    // (memory -> RAM read register -> output register).
    always_comb begin
        push          = winc && !wfull_q;
        pop           = rinc && !rempty_q;
        out_valid     = (MODE == READ_FWFT) && !rempty_q;
        count_nxt     = count_q + CW'(push) - CW'(pop);
        mem_words     = count_q - CW'(mid_valid_q) - CW'(out_valid);
        out_load      = 1'b0;
        ram_ren       = pop;
        mid_valid_nxt = 1'b0;
        rempty_nxt    = (count_nxt == '0);
        // A pop colliding with a push into an empty FIFO is not an underflow.
        ovf_set       = winc && wfull_q;
        udf_set       = rinc && rempty_q && !push;
        if (MODE == READ_FWFT) begin
            out_load      = mid_valid_q && (!out_valid || pop);
            ram_ren       = (mem_words != '0) && (!mid_valid_q || out_load);
            mid_valid_nxt = ram_ren || (mid_valid_q && !out_load);
            rempty_nxt    = !(mid_valid_q || (out_valid && !pop));
        end
    end

    // Pointers, count, flags and output register.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr            <= '0;
            rptr            <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            walmost_full_q  <= (AFULL_C == '0);
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            mid_valid_q     <= 1'b0;
            out_q           <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ASIZE'(1);
            end
            if (ram_ren) begin
                rptr <= rptr + ASIZE'(1);
            end
            if (out_load) begin
                out_q <= ram_rdata;
            end
            count_q         <= count_nxt;
            wfull_q         <= (count_nxt == DEPTH_C);
            walmost_full_q  <= (count_nxt >= AFULL_C);
            rempty_q        <= rempty_nxt;
            ralmost_empty_q <= (count_nxt <= AEMPTY_C);
            mid_valid_q     <= mid_valid_nxt;
            overflow_q      <= ovf_set || (overflow_q && !clr_err);
            underflow_q     <= udf_set || (underflow_q && !clr_err);
        end
    end

    assign rdata         = (MODE == READ_FWFT) ? out_q : ram_rdata;
    assign count         = count_q;
    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: standard-mode FIFO against a queue model, plus an FWFT instance.
module tb_sync_fifo_ctrl;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned AFULL  = DEPTH - 4;
    localparam int unsigned AEMPTY = 4;

    logic       clk = 1'b0;
    logic       wrst_n, winc, rinc, clr_err;
    logic [7:0] wdata;

    logic       s_wfull, s_walmost_full, s_rempty, s_ralmost_empty, s_overflow, s_underflow;
    logic [7:0] s_rdata;
    logic [8:0] s_count;
    logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
    logic [7:0] f_rdata;
    logic [8:0] f_count;

    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    bit         m_ovf, m_udf;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(8), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(0)) u_std (
        .wclk(clk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .wfull(s_wfull),
        .walmost_full(s_walmost_full), .rinc(rinc), .rdata(s_rdata), .rempty(s_rempty),
        .ralmost_empty(s_ralmost_empty), .count(s_count), .overflow(s_overflow),
        .underflow(s_underflow), .clr_err(clr_err)
    );

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(8), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(1)) u_fwft (
        .wclk(clk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .wfull(f_wfull),
        .walmost_full(f_walmost_full), .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
        .ralmost_empty(f_ralmost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .clr_err(clr_err)
    );

    // One clock of stimulus; the queue model advances from the pre-edge state.
    task automatic drive_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit m_push, m_pop;
        winc = w; wdata = d; rinc = r; clr_err = c;
        m_push = w && (mq.size() < DEPTH);
        m_pop  = r && (mq.size() > 0);
        if (w && mq.size() == DEPTH) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && mq.size() == 0 && !m_push) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        if (m_pop) m_rdata = mq.pop_front();
        if (m_push) mq.push_back(d);
        @(posedge clk); #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    endtask

    task automatic apply_reset(input logic w, input logic r, input logic c);
        wrst_n = 1'b0; winc = w; rinc = r; clr_err = c; wdata = 8'h33;
        @(posedge clk); #1;
        wrst_n = 1'b1; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        mq.delete(); m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 1'b0, 1'b0);
        apply_reset(1'b0, 1'b0, 1'b0);
        n_checks++; if (s_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", s_count); end
        n_checks++; if (s_wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b expected 0", s_wfull); end
        n_checks++; if (s_walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", s_walmost_full); end
        n_checks++; if (s_rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", s_rempty); end
        n_checks++; if (s_ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", s_ralmost_empty); end
        n_checks++; if (s_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", s_rdata); end
        n_checks++; if (s_overflow !== 1'b0 || s_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", s_overflow, s_underflow); end
        n_checks++; if (f_rempty !== 1'b1 || f_count !== 9'd0 || f_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_fwft: got rempty=%b count=%0d rdata=%h expected 1/0/00", f_rempty, f_count, f_rdata); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
            n_checks++; if (s_count !== 9'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", s_count, i + 1); end
            n_checks++; if (s_walmost_full !== ((i + 1) >= int'(AFULL))) begin n_fail++; $display("FAIL fill_afull at %0d: got %b", i + 1, s_walmost_full); end
            n_checks++; if (s_wfull !== ((i + 1) == 256)) begin n_fail++; $display("FAIL fill_wfull at %0d: got %b", i + 1, s_wfull); end
        end
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        n_checks++; if (s_overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b expected 1", s_overflow); end
        n_checks++; if (s_count !== 9'd256) begin n_fail++; $display("FAIL fill_count_after_ovf: got %0d expected 256", s_count); end
    endtask

    task automatic test_drain();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (s_overflow !== 1'b0) begin n_fail++; $display("FAIL drain_clr_err: got %b expected 0", s_overflow); end
        for (int i = 0; i < 256; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (s_rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_rdata: got %h expected %h", s_rdata, 8'(i)); end
            n_checks++; if (s_count !== 9'(255 - i)) begin n_fail++; $display("FAIL drain_count: got %0d expected %0d", s_count, 255 - i); end
            n_checks++; if (s_ralmost_empty !== ((255 - i) <= int'(AEMPTY))) begin n_fail++; $display("FAIL drain_aempty at %0d: got %b", 255 - i, s_ralmost_empty); end
            n_checks++; if (s_rempty !== (i == 255)) begin n_fail++; $display("FAIL drain_rempty at %0d: got %b", 255 - i, s_rempty); end
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (s_underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: got %b expected 1", s_underflow); end
        n_checks++; if (s_rdata !== 8'hFF || s_count !== 9'd0) begin n_fail++; $display("FAIL drain_hold: got rdata=%h count=%0d expected ff/0", s_rdata, s_count); end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        // Full: only the pop is taken, 0xEE is lost.
        drive_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        n_checks++; if (s_count !== 9'd255) begin n_fail++; $display("FAIL simul_full_count: got %0d expected 255", s_count); end
        n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL simul_full_rdata: got %h expected %h", s_rdata, m_rdata); end
        n_checks++; if (s_overflow !== m_ovf) begin n_fail++; $display("FAIL simul_full_ovf: got %b expected %b", s_overflow, m_ovf); end
        for (int i = 0; i < 55; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        // Mid-level: both taken, count holds, order kept.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
            n_checks++; if (s_count !== 9'd200) begin n_fail++; $display("FAIL simul_mid_count: got %0d expected 200", s_count); end
            n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL simul_mid_rdata: got %h expected %h", s_rdata, m_rdata); end
        end
        while (mq.size() > 0) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL simul_drain_rdata: got %h expected %h", s_rdata, m_rdata); end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Empty: only the push is taken, no underflow.
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b0);
        n_checks++; if (s_count !== 9'd1) begin n_fail++; $display("FAIL simul_empty_count: got %0d expected 1", s_count); end
        n_checks++; if (s_underflow !== 1'b0) begin n_fail++; $display("FAIL simul_empty_udf: got %b expected 0", s_underflow); end
        n_checks++; if (s_rempty !== 1'b0) begin n_fail++; $display("FAIL simul_empty_rempty: got %b expected 0", s_rempty); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (s_rdata !== 8'h77) begin n_fail++; $display("FAIL simul_empty_rdata: got %h expected 77", s_rdata); end
    endtask

    task automatic test_fwft();
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        n_checks++; if (f_rempty !== 1'b1 || f_count !== 9'd1) begin n_fail++; $display("FAIL fwft_edge0: got rempty=%b count=%0d expected 1/1", f_rempty, f_count); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (f_rempty !== 1'b1) begin n_fail++; $display("FAIL fwft_edge1_rempty: got %b expected 1", f_rempty); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++; if (f_rempty !== 1'b0 || f_rdata !== 8'hA5) begin n_fail++; $display("FAIL fwft_edge2: got rempty=%b rdata=%h expected 0/a5", f_rempty, f_rdata); end
        drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        n_checks++; if (f_rdata !== 8'hA5 || f_count !== 9'd2) begin n_fail++; $display("FAIL fwft_push2: got rdata=%h count=%0d expected a5/2", f_rdata, f_count); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (f_rdata !== 8'h5A || f_rempty !== 1'b0 || f_count !== 9'd1) begin n_fail++; $display("FAIL fwft_pop1: got rdata=%h rempty=%b count=%0d expected 5a/0/1", f_rdata, f_rempty, f_count); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (f_rempty !== 1'b1 || f_count !== 9'd0) begin n_fail++; $display("FAIL fwft_pop2: got rempty=%b count=%0d expected 1/0", f_rempty, f_count); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (f_underflow !== 1'b1) begin n_fail++; $display("FAIL fwft_underflow: got %b expected 1", f_underflow); end
    endtask

    task automatic test_wraparound();
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            n_checks++; if (s_count !== 9'(mq.size())) begin n_fail++; $display("FAIL wrap_count cycle %0d: got %0d expected %0d", i, s_count, mq.size()); end
            n_checks++; if (s_rdata !== m_rdata) begin n_fail++; $display("FAIL wrap_rdata cycle %0d: got %h expected %h", i, s_rdata, m_rdata); end
            n_checks++; if (s_rempty !== (mq.size() == 0) || s_wfull !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL wrap_flags cycle %0d: got rempty=%b wfull=%b", i, s_rempty, s_wfull); end
            n_checks++; if (s_overflow !== m_ovf || s_underflow !== m_udf) begin n_fail++; $display("FAIL wrap_err cycle %0d: got %b%b expected %b%b", i, s_overflow, s_underflow, m_ovf, m_udf); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (s_underflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_udf_pre: got %b expected 1", s_underflow); end
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        n_checks++; if (s_count !== 9'd100) begin n_fail++; $display("FAIL rstmid_count_pre: got %0d expected 100", s_count); end
        apply_reset(1'b1, 1'b1, 1'b1);
        n_checks++; if (s_count !== 9'd0 || s_wfull !== 1'b0 || s_walmost_full !== 1'b0) begin n_fail++; $display("FAIL rstmid_wside: got count=%0d wfull=%b afull=%b expected 0/0/0", s_count, s_wfull, s_walmost_full); end
        n_checks++; if (s_rempty !== 1'b1 || s_ralmost_empty !== 1'b1 || s_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rside: got rempty=%b aempty=%b rdata=%h expected 1/1/00", s_rempty, s_ralmost_empty, s_rdata); end
        n_checks++; if (s_overflow !== 1'b0 || s_underflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b%b expected 00", s_overflow, s_underflow); end
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        n_checks++; if (s_count !== 9'd3) begin n_fail++; $display("FAIL rstmid_count_post: got %0d expected 3", s_count); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (s_rdata !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected %h", s_rdata, 8'(8'h10 + i)); end
        end
        n_checks++; if (s_rempty !== 1'b1) begin n_fail++; $display("FAIL rstmid_rempty_post: got %b expected 1", s_rempty); end
    endtask

    initial begin
        wrst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_fwft();
        test_wraparound();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
